matmul_seq_ctrl: RTL and testbench
==================================

# matmul_seq_ctrl

Sequencer for the matrix-multiply datapath. It accepts a start command carrying the operand dimensions and a scratchpad target. It then drives the accumulator clear, the skewed operand-feed wavefront into the MAX_DIM×MAX_DIM processing array, the pipeline drain, and the row-by-row write-back of C into the selected scratchpad target. It sits between the register/bus front end (start/done) and the compute array plus scratchpad write port.

## Interface
Parameters:
- MAX_DIM, 4: array dimension (BUS_WIDTH/DATA_WIDTH); max N, K, M.
- SP_NTARGETS, 4: number of scratchpad targets for C.
- PIPE_LAT, 2: array output latency after the last feed step, in cycles (≥1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  start command; sampled in IDLE only.
- n_dim_i  in  $clog2(MAX_DIM)  rows of A minus 1.
- k_dim_i  in  $clog2(MAX_DIM)  cols of A / rows of B minus 1.
- m_dim_i  in  $clog2(MAX_DIM)  cols of B minus 1.
- sp_target_i  in  $clog2(SP_NTARGETS)  scratchpad target for C.
- mode_bias_i  in  1  (MATMUL_BIAS_EN only) accumulate onto existing C.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle completion pulse.
- clear_acc_o  out  1  one-cycle accumulator clear.
- load_bias_o  out  1  (MATMUL_BIAS_EN only) one-cycle bias load.
- feed_valid_o  out  1  array feed enable.
- feed_step_o  out  $clog2(3*MAX_DIM)  wavefront step index.
- wr_en_o  out  1  write request to the scratchpad.
- wr_ready_i  in  1  scratchpad accepts the write this cycle.
- wr_row_o  out  $clog2(MAX_DIM)  C row being written.
- wr_target_o  out  $clog2(SP_NTARGETS)  latched target.

## Operation
- FSM states: IDLE → CLEAR → FEED → DRAIN → WRITE → DONE → IDLE.
- IDLE: when start_i=1, latch the dims, sp_target_i and mode_bias_i, then go to CLEAR. A start_i in any other state is ignored and is not queued.
- CLEAR, 1 cycle: assert clear_acc_o. With bias enabled and the latched mode_bias=1, assert load_bias_o instead; the two are never asserted together.
- FEED: lasts S = (N+K+M−2) cycles, where N, K, M are the real dimensions (field+1). feed_valid_o=1 and feed_step_o counts 0..S−1. Range of S: 1..(3·MAX_DIM−2).
- DRAIN: PIPE_LAT cycles. All strobes are low.
- WRITE: wr_en_o=1 with wr_row_o starting at 0. On wr_en_o&&wr_ready_i the row advances. After row N−1 is accepted, go to DONE. wr_en_o stays high while wr_ready_i=0, and wr_row_o holds.
- DONE, 1 cycle: done_o=1 and busy_o=1. The next state is IDLE.
- wr_target_o holds the latched target from CLEAR through DONE, and keeps its value in IDLE.
- Counters are unsigned and saturate-free. They reset to 0 on every state entry, so there is no wrap-around.

## Timing
- Reset values: all outputs 0, state IDLE, latched fields 0. rst_i asserted mid-operation forces IDLE at once, and all strobes drop asynchronously.
- Latency from start_i (cycle 0), assuming wr_ready_i stays high: 1 + S + PIPE_LAT + N cycles; done_o is asserted in the following cycle.
- All outputs are registered state decodes. There is no combinational path from any input to any output.
- A start_i in the same cycle that done_o is high is ignored, because the state is DONE. The earliest accepted restart is the cycle after done_o.
- wr_ready_i is ignored outside WRITE.

## Configuration
- MATMUL_BIAS_EN defined:
  - mode_bias_i and load_bias_o exist.
  - mode_bias=1 replaces the CLEAR pulse with a load_bias_o pulse, so C accumulates onto the prior target contents.
- Undefined:
  - Both ports are absent.
  - CLEAR always asserts clear_acc_o.

## Test plan
- 4×4×4 (all dims 3), PIPE_LAT=2, wr_ready_i=1, start at cycle 0:
  - clear_acc_o at cycle 1.
  - feed_valid_o on cycles 2–11, with feed_step_o 0–9.
  - wr_en_o on cycles 14–17, with rows 0–3.
  - done_o at cycle 18.
- 1×1×1:
  - clear at cycle 1.
  - one feed at cycle 2, with step 0.
  - write row 0 at cycle 5.
  - done at cycle 6.
- N=2 (K=M=1), target 3, with wr_ready_i low for 3 cycles on row 1:
  - wr_row_o holds 1 and wr_en_o stays high.
  - done_o is asserted one cycle after the accepting edge.
  - wr_target_o=3 throughout.
- start_i pulsed during FEED and during DONE: no effect, and exactly one done_o.
- rst_i asserted mid-FEED: all outputs 0 immediately. A new start then runs a full sequence from CLEAR.
- With MATMUL_BIAS_EN and mode_bias_i=1: load_bias_o is asserted at cycle 1 and clear_acc_o stays 0. With mode_bias_i=0 the behaviour matches the first test.

Source files
------------

// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: sequencer for the matrix-multiply datapath.
// Walks IDLE -> CLEAR -> FEED -> DRAIN -> WRITE -> DONE -> IDLE, driving the
// accumulator clear, the skewed operand wavefront, the pipeline drain and the
// row-by-row write-back of C into the selected scratchpad target.
// Optional feature macro: MATMUL_BIAS_EN (adds mode_bias_i / load_bias_o so a
// job can load the prior C contents as a bias instead of clearing).
// Every output is a flop loaded from the next-state decode, so there is no
// combinational path from any input to any output.
module matmul_seq_ctrl #(
    parameter int MAX_DIM     = 4,
    parameter int SP_NTARGETS = 4,
    parameter int PIPE_LAT    = 2,
    localparam int DIM_W  = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1,
    localparam int TGT_W  = (SP_NTARGETS > 1) ? $clog2(SP_NTARGETS) : 1,
    localparam int STEP_W = $clog2(3 * MAX_DIM)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DIM_W-1:0]  n_dim_i,
    input  logic [DIM_W-1:0]  k_dim_i,
    input  logic [DIM_W-1:0]  m_dim_i,
    input  logic [TGT_W-1:0]  sp_target_i,
`ifdef MATMUL_BIAS_EN
    input  logic              mode_bias_i,
    output logic              load_bias_o,
`endif
    output logic              busy_o,
    output logic              done_o,
    output logic              clear_acc_o,
    output logic              feed_valid_o,
    output logic [STEP_W-1:0] feed_step_o,
    output logic              wr_en_o,
    input  logic              wr_ready_i,
    output logic [DIM_W-1:0]  wr_row_o,
    output logic [TGT_W-1:0]  wr_target_o
);

    // The shared counter must hold the last feed step and the last drain cycle.
    localparam int CNT_MAX = (3 * MAX_DIM > PIPE_LAT) ? 3 * MAX_DIM : PIPE_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t             stateR;
    state_t             nextStateS;
    logic [CNT_W-1:0]   cntR;
    logic [CNT_W-1:0]   nextCntS;
    logic               latchS;
    logic               useBiasS;

    logic [DIM_W-1:0]   nR;
    logic [DIM_W-1:0]   kR;
    logic [DIM_W-1:0]   mR;
    logic [TGT_W-1:0]   targetR;

    logic [CNT_W-1:0]   feedLastS;
    logic [CNT_W-1:0]   drainLastS;
    logic [CNT_W-1:0]   rowLastS;

    logic               busyR;
    logic               doneR;
    logic               clearR;
    logic               feedValidR;
    logic [STEP_W-1:0]  feedStepR;
    logic               wrEnR;
    logic [DIM_W-1:0]   wrRowR;

    // Feed length S = N+K+M-2 with N = n+1 etc., so the last step index is n+k+m.
    assign feedLastS  = CNT_W'(nR) + CNT_W'(kR) + CNT_W'(mR);
    assign drainLastS = CNT_W'(PIPE_LAT - 1);
    assign rowLastS   = CNT_W'(nR);

`ifdef MATMUL_BIAS_EN
    logic biasR;

    // Bias mode for the upcoming CLEAR cycle: fresh input when starting, else latched.
    always_comb begin
        useBiasS = biasR;
        if (latchS) begin
            useBiasS = mode_bias_i;
        end else begin
            useBiasS = biasR;
        end
    end
`else
    assign useBiasS = 1'b0;
`endif

    // Next-state and counter logic; the counter restarts at zero on every state entry.
    always_comb begin
        nextStateS = stateR;
        nextCntS   = cntR;
        latchS     = 1'b0;
        case (stateR)
            IDLE: begin
                if (start_i) begin
                    nextStateS = CLEAR;
                    nextCntS   = {CNT_W{1'b0}};
                    latchS     = 1'b1;
                end else begin
                    nextStateS = IDLE;
                end
            end
            CLEAR: begin
                nextStateS = FEED;
                nextCntS   = {CNT_W{1'b0}};
            end
            FEED: begin
                if (cntR == feedLastS) begin
                    nextStateS = DRAIN;
                    nextCntS   = {CNT_W{1'b0}};
                end else begin
                    nextCntS   = cntR + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (cntR == drainLastS) begin
                    nextStateS = WRITE;
                    nextCntS   = {CNT_W{1'b0}};
                end else begin
                    nextCntS   = cntR + CNT_W'(1);
                end
            end
            WRITE: begin
                if (wr_ready_i) begin
                    if (cntR == rowLastS) begin
                        nextStateS = DONE;
                        nextCntS   = {CNT_W{1'b0}};
                    end else begin
                        nextCntS   = cntR + CNT_W'(1);
                    end
                end else begin
                    nextCntS = cntR;
                end
            end
            DONE: begin
                nextStateS = IDLE;
                nextCntS   = {CNT_W{1'b0}};
            end
            default: begin
                nextStateS = IDLE;
                nextCntS   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stateR <= IDLE;
            cntR   <= {CNT_W{1'b0}};
        end else begin
            stateR <= nextStateS;
            cntR   <= nextCntS;
        end
    end

    // Command fields captured on an accepted start; they hold through IDLE afterwards.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            nR      <= {DIM_W{1'b0}};
            kR      <= {DIM_W{1'b0}};
            mR      <= {DIM_W{1'b0}};
            targetR <= {TGT_W{1'b0}};
        end else if (latchS) begin
            nR      <= n_dim_i;
            kR      <= k_dim_i;
            mR      <= m_dim_i;
            targetR <= sp_target_i;
        end
    end

`ifdef MATMUL_BIAS_EN
    logic loadBiasR;

    // Bias mode flag and the bias-load strobe that replaces the clear pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            biasR     <= 1'b0;
            loadBiasR <= 1'b0;
        end else begin
            biasR     <= useBiasS;
            loadBiasR <= (nextStateS == CLEAR) && useBiasS;
        end
    end

    assign load_bias_o = loadBiasR;
`endif

    // Output flops loaded from the decode of the state being entered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busyR      <= 1'b0;
            doneR      <= 1'b0;
            clearR     <= 1'b0;
            feedValidR <= 1'b0;
            feedStepR  <= {STEP_W{1'b0}};
            wrEnR      <= 1'b0;
            wrRowR     <= {DIM_W{1'b0}};
        end else begin
            busyR      <= (nextStateS != IDLE);
            doneR      <= (nextStateS == DONE);
            clearR     <= (nextStateS == CLEAR) && !useBiasS;
            feedValidR <= (nextStateS == FEED);
            feedStepR  <= (nextStateS == FEED) ? STEP_W'(nextCntS) : {STEP_W{1'b0}};
            wrEnR      <= (nextStateS == WRITE);
            wrRowR     <= (nextStateS == WRITE) ? DIM_W'(nextCntS) : {DIM_W{1'b0}};
        end
    end

    assign busy_o       = busyR;
    assign done_o       = doneR;
    assign clear_acc_o  = clearR;
    assign feed_valid_o = feedValidR;
    assign feed_step_o  = feedStepR;
    assign wr_en_o      = wrEnR;
    assign wr_row_o     = wrRowR;
    assign wr_target_o  = targetR;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Self-checking bench for matmul_seq_ctrl. Expected outputs per cycle come
// from the job timeline: clear at cycle 1, S = N+K+M-2 feed cycles, PIPE_LAT
// drain cycles, then one write per accepted row and done after the last one.
module tb_matmul_seq_ctrl;

    localparam int MAX_DIM     = 4;
    localparam int SP_NTARGETS = 4;
    localparam int PIPE_LAT    = 2;
`ifdef MATMUL_BIAS_EN
    localparam bit BIAS_EN = 1'b1;
`else
    localparam bit BIAS_EN = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic [1:0] n_dim_i;
    logic [1:0] k_dim_i;
    logic [1:0] m_dim_i;
    logic [1:0] sp_target_i;
    logic       mode_bias_i;
    logic       load_bias_o;
    logic       busy_o;
    logic       done_o;
    logic       clear_acc_o;
    logic       feed_valid_o;
    logic [3:0] feed_step_o;
    logic       wr_en_o;
    logic       wr_ready_i;
    logic [1:0] wr_row_o;
    logic [1:0] wr_target_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    matmul_seq_ctrl #(
        .MAX_DIM     (MAX_DIM),
        .SP_NTARGETS (SP_NTARGETS),
        .PIPE_LAT    (PIPE_LAT)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .n_dim_i      (n_dim_i),
        .k_dim_i      (k_dim_i),
        .m_dim_i      (m_dim_i),
        .sp_target_i  (sp_target_i),
`ifdef MATMUL_BIAS_EN
        .mode_bias_i  (mode_bias_i),
        .load_bias_o  (load_bias_o),
`endif
        .busy_o       (busy_o),
        .done_o       (done_o),
        .clear_acc_o  (clear_acc_o),
        .feed_valid_o (feed_valid_o),
        .feed_step_o  (feed_step_o),
        .wr_en_o      (wr_en_o),
        .wr_ready_i   (wr_ready_i),
        .wr_row_o     (wr_row_o),
        .wr_target_o  (wr_target_o)
    );

`ifndef MATMUL_BIAS_EN
    assign load_bias_o = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkIdle(input string tag, input int tgt);
        chk({tag, " busy"}, busy_o, 0);
        chk({tag, " done"}, done_o, 0);
        chk({tag, " clear"}, clear_acc_o, 0);
        chk({tag, " loadBias"}, load_bias_o, 0);
        chk({tag, " feedValid"}, feed_valid_o, 0);
        chk({tag, " feedStep"}, feed_step_o, 0);
        chk({tag, " wrEn"}, wr_en_o, 0);
        chk({tag, " wrRow"}, wr_row_o, 0);
        chk({tag, " wrTarget"}, wr_target_o, tgt);
    endtask

    // readyMode: 0 = always ready, 1 = random (at most 3 stalls in a row),
    // 2 = three stall cycles on row 1. pokeStart drives start_i during FEED and DONE.
    task automatic runJob(input int n, input int k, input int m, input int tgt,
                          input bit bias, input int readyMode, input bit pokeStart,
                          output int dutDone);
        int  bigN;
        int  s;
        int  wrStart;
        int  rows;
        int  stall;
        int  lastAcc;
        bit  effBias;
        bit  eFeed;
        bit  eWr;
        bit  eDone;
        bit  rdy;
        string t;
        bigN    = n + 1;
        s       = (n + 1) + (k + 1) + (m + 1) - 2;
        wrStart = 2 + s + PIPE_LAT;
        rows    = 0;
        stall   = 0;
        lastAcc = -10;
        effBias = bias && BIAS_EN;
        dutDone = -1;

        @(negedge clk_i);
        n_dim_i     = 2'(n);
        k_dim_i     = 2'(k);
        m_dim_i     = 2'(m);
        sp_target_i = 2'(tgt);
        mode_bias_i = bias;
        start_i     = 1'b1;
        wr_ready_i  = 1'b0;
        @(posedge clk_i);
        #1;
        start_i     = 1'b0;
        n_dim_i     = 2'($urandom_range(0, 3));
        k_dim_i     = 2'($urandom_range(0, 3));
        m_dim_i     = 2'($urandom_range(0, 3));
        sp_target_i = 2'($urandom_range(0, 3));
        mode_bias_i = 1'($urandom_range(0, 1));

        for (int c = 1; c < 300; c++) begin
            eFeed = (c >= 2) && (c < 2 + s);
            eWr   = (c >= wrStart) && (rows < bigN);
            eDone = (c == lastAcc + 1);
            t = $sformatf("c%0d", c);
            chk({t, " busy"}, busy_o, 1);
            chk({t, " clear"}, clear_acc_o, (c == 1) && !effBias);
            chk({t, " loadBias"}, load_bias_o, (c == 1) && effBias);
            chk({t, " feedValid"}, feed_valid_o, eFeed);
            chk({t, " feedStep"}, feed_step_o, eFeed ? c - 2 : 0);
            chk({t, " wrEn"}, wr_en_o, eWr);
            chk({t, " wrRow"}, wr_row_o, eWr ? rows : 0);
            chk({t, " done"}, done_o, eDone);
            chk({t, " wrTarget"}, wr_target_o, tgt);
            if (done_o === 1'b1 && dutDone < 0) begin
                dutDone = c;
            end
            if (eWr) begin
                if (readyMode == 0) begin
                    rdy = 1'b1;
                end else if (readyMode == 2) begin
                    rdy = !(rows == 1 && stall < 3);
                end else begin
                    rdy = (stall >= 3) || ($urandom_range(0, 1) == 1);
                end
                if (rdy) begin
                    stall = 0;
                    rows++;
                    if (rows == bigN) begin
                        lastAcc = c;
                    end
                end else begin
                    stall++;
                end
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            wr_ready_i = rdy;
            if (pokeStart && (c == 3 || eDone)) begin
                start_i = 1'b1;
            end
            @(posedge clk_i);
            #1;
            start_i = 1'b0;
            if (eDone) begin
                break;
            end
        end
        wr_ready_i = 1'b0;
        checkIdle("postJob1", tgt);
        @(posedge clk_i);
        #1;
        checkIdle("postJob2", tgt);
    endtask

    initial begin
        int d;
        rst_i       = 1'b0;
        start_i     = 1'b0;
        n_dim_i     = 2'd0;
        k_dim_i     = 2'd0;
        m_dim_i     = 2'd0;
        sp_target_i = 2'd0;
        mode_bias_i = 1'b0;
        wr_ready_i  = 1'b0;
        #1;
        rst_i = 1'b1;
        #1;
        checkIdle("reset", 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        checkIdle("afterReset", 0);

        // 4x4x4, always ready: done at cycle 18.
        runJob(3, 3, 3, 1, 1'b0, 0, 1'b0, d);
        chk("lat444", d, 18);

        // 1x1x1: done at cycle 6.
        runJob(0, 0, 0, 2, 1'b0, 0, 1'b0, d);
        chk("lat111", d, 6);

        // N=2, target 3, three stall cycles on row 1: done at cycle 11.
        runJob(1, 0, 0, 3, 1'b0, 2, 1'b0, d);
        chk("latStall", d, 11);

        // Start pulses during FEED and DONE are neither honoured nor queued.
        runJob(3, 3, 3, 0, 1'b0, 0, 1'b1, d);
        chk("latPoke", d, 18);

        // Reset in the middle of FEED drops everything at once.
        @(negedge clk_i);
        n_dim_i     = 2'd3;
        k_dim_i     = 2'd3;
        m_dim_i     = 2'd3;
        sp_target_i = 2'd2;
        start_i     = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2;
        chk("preRst feedValid", feed_valid_o, 1);
        chk("preRst feedStep", feed_step_o, 2);
        rst_i = 1'b1;
        #1;
        checkIdle("midRst", 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        runJob(3, 3, 3, 1, 1'b0, 0, 1'b0, d);
        chk("latAfterRst", d, 18);

        // Bias mode (load_bias_o replaces clear_acc_o when the feature is built in).
        runJob(3, 3, 3, 2, 1'b1, 0, 1'b0, d);
        chk("latBias", d, 18);

        // Randomized jobs.
        for (int j = 0; j < 25; j++) begin
            runJob($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1, 1'b0, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
